vout_nibble_writer: RTL

- Downstream consumer of the Ethernet RX byte stream. Parses frames and feeds the video_out write FIFO one 4-bit nibble per clock.
- The first byte of each frame is a header: command in [7:4], argument in [3:0]. Only command 4'h1 (TAPE_WRITE) carries payload.
- Each payload byte is split into two nibbles, high nibble first, and written to the FIFO under FIFO-level flow control.
- Sits between the Ethernet MAC RX interface and the video_out FIFO write port, alongside the system state manager.

---
 rtl/vout_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/vout_nibble_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vout_pkg.sv
// Shared constants and FSM state type for the video_out nibble writer.
package vout_pkg;

    localparam int unsigned FIFO_DEPTH = 2048;

    // Header command codes (header byte [7:4]); only CMD_WRITE carries payload.
    localparam logic [3:0] CMD_NOP    = 4'h0;
    localparam logic [3:0] CMD_WRITE  = 4'h1;
    localparam logic [3:0] CMD_STATUS = 4'h2;
    localparam logic [3:0] CMD_RESET  = 4'hF;

    typedef enum logic [1:0] {
        HDR        = 2'd0,
        DISCARD    = 2'd1,
        PAYLOAD_HI = 2'd2,
        PAYLOAD_LO = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vout_nibble_writer.sv
// Parses RX frames and writes TAPE_WRITE payload to the video_out FIFO as nibbles,
// high nibble first, only while the FIFO has enough headroom.
module vout_nibble_writer
    import vout_pkg::*;
#(
    parameter int unsigned HEADROOM = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    input  logic             rx_user,
    output logic             rx_ready,
    output logic [3:0]       vout_fifow_data,
    output logic             vout_fifow_clock,
    output logic             vout_fifow_request,
    input  logic [10:0]      vout_fifow_used_words,
    output logic             frame_active,
    output logic [7:0]       last_header,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e     state_q, state_d;
    logic       active_q, active_d;
    logic [7:0] header_q, header_d;
    logic [3:0] lo_nib_q, lo_nib_d;
    logic       last_q, last_d;
    logic       user_q, user_d;
    logic       req_q, req_d;
    logic [3:0] data_q, data_d;

    logic [11:0] free_words;
    logic        room;
    logic        ready_raw;
    logic        xfer;
    logic        ok_inc, err_inc, stall_inc;

    assign free_words = 12'(FIFO_DEPTH) - {1'b0, vout_fifow_used_words};
    assign room       = (free_words >= 12'(HEADROOM));

    always_comb begin
        case (state_q)
            HDR:        ready_raw = 1'b1;
            DISCARD:    ready_raw = 1'b1;
            PAYLOAD_HI: ready_raw = room;
            default:    ready_raw = 1'b0;
        endcase
    end

    // Gated by rst so nothing is accepted while reset is held.
    assign rx_ready = ready_raw & ~rst;
    assign xfer     = rx_valid & rx_ready;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        header_d  = header_q;
        lo_nib_d  = lo_nib_q;
        last_d    = last_q;
        user_d    = user_q;
        req_d     = 1'b0;
        data_d    = data_q;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            HDR: begin
                if (xfer) begin
                    header_d = rx_data;
                    if (rx_last) begin
                        err_inc = rx_user;
                    end else if (rx_data[7:4] == CMD_WRITE) begin
                        state_d  = PAYLOAD_HI;
                        active_d = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (xfer && rx_last) begin
                    state_d = HDR;
                    err_inc = rx_user;
                end
            end
            PAYLOAD_HI: begin
                if (xfer) begin
                    req_d    = 1'b1;
                    data_d   = rx_data[7:4];
                    lo_nib_d = rx_data[3:0];
                    last_d   = rx_last;
                    user_d   = rx_user;
                    state_d  = PAYLOAD_LO;
                end
                stall_inc = rx_valid & ~room;
            end
            PAYLOAD_LO: begin
                req_d  = 1'b1;
                data_d = lo_nib_q;
                if (last_q) begin
                    state_d  = HDR;
                    active_d = 1'b0;
                    ok_inc   = ~user_q;
                    err_inc  = user_q;
                end else begin
                    state_d = PAYLOAD_HI;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HDR;
            active_q <= 1'b0;
            header_q <= 8'h00;
            lo_nib_q <= 4'h0;
            last_q   <= 1'b0;
            user_q   <= 1'b0;
            req_q    <= 1'b0;
            data_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            header_q <= header_d;
            lo_nib_q <= lo_nib_d;
            last_q   <= last_d;
            user_q   <= user_d;
            req_q    <= req_d;
            data_q   <= data_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frames_ok (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ok_inc),
        .cnt_o (frames_ok)
    );

    sat_counter #(.CNT_W(CNT_W)) u_frames_err (
        .clk   (clk),
        .rst   (rst),
        .en_i  (err_inc),
        .cnt_o (frames_err)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_inc),
        .cnt_o (stall_cycles)
    );

    assign vout_fifow_clock   = clk;
    assign vout_fifow_request = req_q;
    assign vout_fifow_data    = data_q;
    assign frame_active       = active_q;
    assign last_header        = header_q;

endmodule
